// File: rtl/cache_pkg.sv
// cache_pkg: shared types and width helpers for the data-cache controller.
//   state_e  - controller state encoding (3 bits, every code is a legal state)
//   ctrl_t   - bundle of the single-bit controller outputs
//   beat_w() - beat counter width for a given beats-per-line (minimum 1)
//   idx_w()  - line index width for a given line count (minimum 1)
package cache_pkg;

  typedef enum logic [2:0] {
    StIdle        = 3'd0,
    StCompareTag  = 3'd1,
    StWriteBack   = 3'd2,
    StAllocate    = 3'd3,
    StCacheAccess = 3'd4,
    StMemWrite    = 3'd5,
    StFlushCheck  = 3'd6,
    StFlushWb     = 3'd7
  } state_e;

  typedef struct packed {
    logic cache_rden;
    logic cache_wren;
    logic cache_insel;
    logic mem_rden;
    logic mem_wren;
    logic set_dirty;
    logic set_valid;
    logic replace_tag;
    logic tag_sel;
    logic index_sel;
    logic stall;
    logic flush_done;
  } ctrl_t;

  // A one-beat line still needs a 1-bit beat_idx port.
  function automatic int unsigned beat_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/cache_beat_cnt.sv
// cache_beat_cnt: wrap-around beat counter for memory bursts.
//   clk   - clock, rising edge
//   rst   - asynchronous reset, active-low
//   inc   - advance by one beat; wraps to 0 after Count-1
//   clear - force count to 0 (wins over inc)
//   count - current beat
//   last  - count is at Count-1
module cache_beat_cnt #(
  parameter int unsigned Count = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [Width-1:0] count,
  output logic             last
);

  localparam logic [Width-1:0] MaxVal = Width'(Count - 1);

  logic [Width-1:0] count_q, count_d;

  assign last  = (count_q == MaxVal);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm_burst.sv
// cache_ctrl_fsm_burst: data-cache controller FSM between the load/store unit and the
// cache arrays / memory. Handles hits, dirty write-back and refill bursts, optional
// no-allocate store misses, and a walk over all lines writing back dirty ones.
//   clk, rst          - clock (rising edge), asynchronous active-low reset
//   cpu_rden/wren     - load / store request (store wins if both)
//   flush_req         - level request to write back every dirty line
//   hit, dirty        - tag compare result and dirty bit of the addressed line
//   mem_ack           - one memory beat accepted/returned
//   cache_rden/wren   - array read / write enable
//   cache_insel       - array write data from memory (1) or CPU (0)
//   mem_rden/wren     - memory read / write burst active
//   set_dirty/valid   - tag bits written with replace_tag
//   replace_tag       - tag/valid/dirty write strobe
//   tag_sel           - memory address uses stored victim tag
//   beat_idx          - current beat within a line
//   flush_idx         - line index during flush
//   index_sel         - array index taken from flush_idx
//   stall             - hold the pipeline
//   flush_done        - one-cycle pulse at the end of a flush
module cache_ctrl_fsm_burst
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES   = 64,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned WRITE_ALLOC = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_rden,
  input  logic                          cpu_wren,
  input  logic                          flush_req,
  input  logic                          hit,
  input  logic                          dirty,
  input  logic                          mem_ack,
  output logic                          cache_rden,
  output logic                          cache_wren,
  output logic                          cache_insel,
  output logic                          mem_rden,
  output logic                          mem_wren,
  output logic                          set_dirty,
  output logic                          set_valid,
  output logic                          replace_tag,
  output logic                          tag_sel,
  output logic [beat_w(BEATS)-1:0]      beat_idx,
  output logic [idx_w(NUM_LINES)-1:0]   flush_idx,
  output logic                          index_sel,
  output logic                          stall,
  output logic                          flush_done
);

  localparam int unsigned BeatW = beat_w(BEATS);
  localparam int unsigned IdxW  = idx_w(NUM_LINES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LINES - 1);

  state_e          state_q, state_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic [IdxW-1:0] flush_idx_q, flush_idx_d;

  logic  cpu_req;
  logic  in_burst;
  logic  burst_ack;
  logic  beat_last;
  logic  beat_done;
  logic  beat_clr;
  logic  flush_last;
  ctrl_t ctrl;

  assign cpu_req    = cpu_rden | cpu_wren;
  // mem_ack only counts as a beat while a burst state owns the memory port.
  assign in_burst   = (state_q == StWriteBack) || (state_q == StAllocate) ||
                      (state_q == StFlushWb);
  assign burst_ack  = in_burst & mem_ack;
  assign beat_done  = burst_ack & beat_last;
  assign beat_clr   = (state_q == StIdle);
  assign flush_last = (flush_idx_q == LastIdx);

  cache_beat_cnt #(
    .Count (BEATS),
    .Width (BeatW)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (burst_ack),
    .clear (beat_clr),
    .count (beat_idx),
    .last  (beat_last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    flush_idx_d = flush_idx_q;
    case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d     = StFlushCheck;
          flush_idx_d = '0;
        end else if (cpu_req) begin
          state_d = StCompareTag;
          rd_d    = cpu_rden & ~cpu_wren;
          wr_d    = cpu_wren;
        end
      end
      StCompareTag, StCacheAccess: begin
        if ((state_q == StCompareTag) && !hit) begin
          if (wr_q && (WRITE_ALLOC == 0)) begin
            state_d = StMemWrite;
          end else if (dirty) begin
            state_d = StWriteBack;
          end else begin
            state_d = StAllocate;
          end
        end else if (cpu_req) begin
          // Back-to-back request: capture it and compare again next cycle.
          state_d = StCompareTag;
          rd_d    = cpu_rden & ~cpu_wren;
          wr_d    = cpu_wren;
        end else begin
          state_d = StIdle;
        end
      end
      StWriteBack: begin
        if (beat_done) state_d = StAllocate;
      end
      StAllocate: begin
        if (beat_done) state_d = StCacheAccess;
      end
      StMemWrite: begin
        if (mem_ack) state_d = StIdle;
      end
      StFlushCheck: begin
        if (dirty) begin
          state_d = StFlushWb;
        end else if (flush_last) begin
          state_d = StIdle;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      StFlushWb: begin
        if (beat_done) begin
          if (flush_last) begin
            state_d = StIdle;
          end else begin
            // The line just written back is now clean, so move straight on.
            state_d     = StFlushCheck;
            flush_idx_d = flush_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ctrl = '0;
    case (state_q)
      StIdle: ;
      StCompareTag: begin
        if (hit) begin
          ctrl.cache_rden  = rd_q;
          ctrl.cache_wren  = wr_q;
          ctrl.replace_tag = wr_q;
          ctrl.set_dirty   = 1'b1;
          ctrl.set_valid   = 1'b1;
        end else if (wr_q && (WRITE_ALLOC == 0)) begin
          ctrl.stall = 1'b1;
        end else if (dirty) begin
          ctrl.tag_sel = 1'b1;
          ctrl.stall   = 1'b1;
        end else begin
          ctrl.stall       = 1'b1;
          ctrl.replace_tag = 1'b1;
          ctrl.set_valid   = 1'b1;
          ctrl.set_dirty   = wr_q;
        end
      end
      StWriteBack: begin
        ctrl.mem_wren   = 1'b1;
        ctrl.cache_rden = 1'b1;
        ctrl.tag_sel    = 1'b1;
        ctrl.stall      = 1'b1;
      end
      StAllocate: begin
        ctrl.mem_rden    = 1'b1;
        ctrl.cache_insel = 1'b1;
        ctrl.cache_wren  = mem_ack;
        ctrl.stall       = 1'b1;
        if (beat_done) begin
          ctrl.replace_tag = 1'b1;
          ctrl.set_valid   = 1'b1;
          ctrl.set_dirty   = wr_q;
        end
      end
      StCacheAccess: begin
        ctrl.cache_rden = rd_q;
        ctrl.cache_wren = wr_q;
      end
      StMemWrite: begin
        ctrl.mem_wren = 1'b1;
        ctrl.stall    = 1'b1;
      end
      StFlushCheck: begin
        ctrl.index_sel  = 1'b1;
        ctrl.stall      = 1'b1;
        ctrl.flush_done = !dirty && flush_last;
      end
      StFlushWb: begin
        ctrl.mem_wren   = 1'b1;
        ctrl.cache_rden = 1'b1;
        ctrl.tag_sel    = 1'b1;
        ctrl.index_sel  = 1'b1;
        ctrl.stall      = 1'b1;
        if (beat_done) begin
          ctrl.replace_tag = 1'b1;
          ctrl.set_valid   = 1'b1;
          ctrl.flush_done  = flush_last;
        end
      end
      default: ctrl = '0;
    endcase
  end

  assign cache_rden  = ctrl.cache_rden;
  assign cache_wren  = ctrl.cache_wren;
  assign cache_insel = ctrl.cache_insel;
  assign mem_rden    = ctrl.mem_rden;
  assign mem_wren    = ctrl.mem_wren;
  assign set_dirty   = ctrl.set_dirty;
  assign set_valid   = ctrl.set_valid;
  assign replace_tag = ctrl.replace_tag;
  assign tag_sel     = ctrl.tag_sel;
  assign index_sel   = ctrl.index_sel;
  assign stall       = ctrl.stall;
  assign flush_done  = ctrl.flush_done;
  assign flush_idx   = flush_idx_q;

endmodule

// File: tb/tb_cache_ctrl_fsm_burst.sv
// Bench for cache_ctrl_fsm_burst: per-cycle stimulus and expected output vectors are
// queued together, then replayed; each replayed cycle compares the DUT outputs.
module tb_cache_ctrl_fsm_burst;

  localparam int unsigned NL = 4;
  localparam int unsigned BT = 4;

  // Bit positions within the 12-bit control field of an observation vector.
  localparam logic [11:0] B_CRD = 12'h800;
  localparam logic [11:0] B_CWR = 12'h400;
  localparam logic [11:0] B_INS = 12'h200;
  localparam logic [11:0] B_MRD = 12'h100;
  localparam logic [11:0] B_MWR = 12'h080;
  localparam logic [11:0] B_SD  = 12'h040;
  localparam logic [11:0] B_SV  = 12'h020;
  localparam logic [11:0] B_RT  = 12'h010;
  localparam logic [11:0] B_TS  = 12'h008;
  localparam logic [11:0] B_IX  = 12'h004;
  localparam logic [11:0] B_ST  = 12'h002;
  localparam logic [11:0] B_FD  = 12'h001;

  localparam logic [11:0] WB_O = B_MWR | B_CRD | B_TS | B_ST;
  localparam logic [11:0] AL_O = B_MRD | B_INS | B_ST;
  localparam logic [11:0] FW_O = B_MWR | B_CRD | B_TS | B_IX | B_ST;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_rden = 1'b0, cpu_wren = 1'b0, flush_req = 1'b0;
  logic hit = 1'b0, dirty = 1'b0, mem_ack = 1'b0;

  logic cache_rden, cache_wren, cache_insel, mem_rden, mem_wren, set_dirty, set_valid;
  logic replace_tag, tag_sel, index_sel, stall, flush_done;
  logic [1:0] beat_idx, flush_idx;

  logic na_cache_rden, na_cache_wren, na_cache_insel, na_mem_rden, na_mem_wren;
  logic na_set_dirty, na_set_valid, na_replace_tag, na_tag_sel, na_index_sel;
  logic na_stall, na_flush_done;
  logic [1:0] na_beat_idx, na_flush_idx;

  logic [15:0] obs, na_obs;

  always #5 clk = ~clk;

  cache_ctrl_fsm_burst #(
    .NUM_LINES   (NL),
    .BEATS       (BT),
    .WRITE_ALLOC (1)
  ) dut (
    .clk (clk), .rst (rst), .cpu_rden (cpu_rden), .cpu_wren (cpu_wren),
    .flush_req (flush_req), .hit (hit), .dirty (dirty), .mem_ack (mem_ack),
    .cache_rden (cache_rden), .cache_wren (cache_wren), .cache_insel (cache_insel),
    .mem_rden (mem_rden), .mem_wren (mem_wren), .set_dirty (set_dirty),
    .set_valid (set_valid), .replace_tag (replace_tag), .tag_sel (tag_sel),
    .beat_idx (beat_idx), .flush_idx (flush_idx), .index_sel (index_sel),
    .stall (stall), .flush_done (flush_done)
  );

  cache_ctrl_fsm_burst #(
    .NUM_LINES   (NL),
    .BEATS       (BT),
    .WRITE_ALLOC (0)
  ) dut_na (
    .clk (clk), .rst (rst), .cpu_rden (cpu_rden), .cpu_wren (cpu_wren),
    .flush_req (flush_req), .hit (hit), .dirty (dirty), .mem_ack (mem_ack),
    .cache_rden (na_cache_rden), .cache_wren (na_cache_wren),
    .cache_insel (na_cache_insel), .mem_rden (na_mem_rden), .mem_wren (na_mem_wren),
    .set_dirty (na_set_dirty), .set_valid (na_set_valid),
    .replace_tag (na_replace_tag), .tag_sel (na_tag_sel), .beat_idx (na_beat_idx),
    .flush_idx (na_flush_idx), .index_sel (na_index_sel), .stall (na_stall),
    .flush_done (na_flush_done)
  );

  assign obs = {cache_rden, cache_wren, cache_insel, mem_rden, mem_wren, set_dirty,
                set_valid, replace_tag, tag_sel, index_sel, stall, flush_done,
                beat_idx, flush_idx};
  assign na_obs = {na_cache_rden, na_cache_wren, na_cache_insel, na_mem_rden,
                   na_mem_wren, na_set_dirty, na_set_valid, na_replace_tag, na_tag_sel,
                   na_index_sel, na_stall, na_flush_done, na_beat_idx, na_flush_idx};

  typedef struct packed {
    logic rd;
    logic wr;
    logic fl;
    logic hit;
    logic dirty;
    logic ack;
  } stim_t;

  stim_t       stim_q[$];
  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic stim_t st(input logic rd, input logic wr, input logic fl,
                               input logic h, input logic d, input logic a);
    return {rd, wr, fl, h, d, a};
  endfunction

  function automatic logic [15:0] ex(input logic [11:0] o, input int b, input int f);
    logic [1:0] bb;
    logic [1:0] ff;
    bb = b[1:0];
    ff = f[1:0];
    return {o, bb, ff};
  endfunction

  task automatic push(input stim_t s, input logic [15:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    @(negedge clk);
    cpu_rden  = s.rd;
    cpu_wren  = s.wr;
    flush_req = s.fl;
    hit       = s.hit;
    dirty     = s.dirty;
    mem_ack   = s.ack;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(st(0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    cpu_rden  = 1'b1;
    flush_req = 1'b1;
    mem_ack   = 1'b1;
    hit       = 1'b1;
    dirty     = 1'b1;
    #2;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outs got=%h exp=%h", obs, 16'h0);
    end
    n_cmp++;
    if (na_obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outs_na got=%h exp=%h", na_obs, 16'h0);
    end
    apply_reset();
    drive(st(0, 0, 0, 0, 0, 0));
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_idle got=%h exp=%h", obs, 16'h0);
    end
  endtask

  task automatic test_load_hit();
    int cyc = 0;
    logic [15:0] e;
    apply_reset();
    push(st(1, 0, 0, 1, 0, 0), ex(12'h0, 0, 0));
    push(st(0, 0, 0, 1, 0, 0), ex(B_CRD | B_SD | B_SV, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), ex(12'h0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL load_hit cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_clean_miss();
    int cyc = 0;
    int stall_cyc = 0;
    logic [15:0] e;
    apply_reset();
    push(st(1, 0, 0, 0, 0, 0), ex(12'h0, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), ex(B_ST | B_RT | B_SV, 0, 0));
    for (int b = 0; b < 4; b++) begin
      push(st(0, 0, 0, 0, 0, 1), ex(AL_O | B_CWR | ((b == 3) ? (B_RT | B_SV) : 12'h0), b, 0));
    end
    push(st(0, 0, 0, 0, 0, 0), ex(B_CRD, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), ex(12'h0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      if (stall) stall_cyc++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL clean_miss cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
    n_cmp++;
    if (stall_cyc != 5) begin
      n_err++;
      $display("FAIL clean_miss_stall_cycles got=%0d exp=5", stall_cyc);
    end
  endtask

  task automatic test_dirty_store_miss();
    int cyc = 0;
    logic [15:0] e;
    apply_reset();
    push(st(0, 1, 0, 0, 0, 0), ex(12'h0, 0, 0));
    push(st(0, 0, 0, 0, 1, 0), ex(B_ST | B_TS, 0, 0));
    for (int b = 0; b < 4; b++) begin
      push(st(0, 0, 0, 0, 1, 0), ex(WB_O, b, 0));
      push(st(0, 0, 0, 0, 1, 1), ex(WB_O, b, 0));
    end
    for (int b = 0; b < 4; b++) begin
      push(st(0, 0, 0, 0, 1, 0), ex(AL_O, b, 0));
      push(st(0, 0, 0, 0, 1, 1),
           ex(AL_O | B_CWR | ((b == 3) ? (B_RT | B_SV | B_SD) : 12'h0), b, 0));
    end
    push(st(0, 0, 0, 0, 0, 0), ex(B_CWR, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), ex(12'h0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL dirty_store_miss cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_no_alloc_store();
    int cyc = 0;
    logic [15:0] e;
    apply_reset();
    push(st(0, 1, 0, 0, 1, 0), ex(12'h0, 0, 0));
    push(st(0, 0, 0, 0, 1, 0), ex(B_ST, 0, 0));
    push(st(0, 0, 0, 0, 1, 0), ex(B_MWR | B_ST, 0, 0));
    push(st(0, 0, 0, 0, 1, 0), ex(B_MWR | B_ST, 0, 0));
    push(st(0, 0, 0, 0, 1, 1), ex(B_MWR | B_ST, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), ex(12'h0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (na_obs !== e) begin
        n_err++;
        $display("FAIL no_alloc_store cyc%0d got=%h exp=%h", cyc, na_obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_flush();
    int cyc = 0;
    int done_cnt = 0;
    logic [15:0] e;
    logic [3:0] dirty_lines = 4'b1010;
    apply_reset();
    // flush_req and a load together: the flush must win.
    push(st(1, 0, 1, 0, 0, 0), ex(12'h0, 0, 0));
    for (int l = 0; l < 4; l++) begin
      push(st(0, 0, 0, 0, dirty_lines[l], 0),
           ex(B_IX | B_ST | ((l == 3 && !dirty_lines[l]) ? B_FD : 12'h0), 0, l));
      if (dirty_lines[l]) begin
        for (int b = 0; b < 4; b++) begin
          push(st(0, 0, 0, 0, 1, 1),
               ex(FW_O | ((b == 3) ? (B_RT | B_SV | ((l == 3) ? B_FD : 12'h0)) : 12'h0),
                  b, l));
        end
      end
    end
    push(st(0, 0, 0, 0, 0, 0), ex(12'h0, 0, 3));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      if (flush_done) done_cnt++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL flush cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL flush_done_pulses got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    logic [15:0] e;
    apply_reset();
    // mem_ack held high throughout: it must not disturb non-burst states.
    push(st(1, 0, 0, 1, 0, 1), ex(12'h0, 0, 0));
    push(st(1, 1, 0, 1, 0, 1), ex(B_CRD | B_SD | B_SV, 0, 0));
    push(st(0, 0, 0, 1, 0, 1), ex(B_CWR | B_RT | B_SD | B_SV, 0, 0));
    push(st(0, 0, 0, 0, 0, 1), ex(12'h0, 0, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    logic [15:0] e;
    apply_reset();
    push(st(1, 0, 0, 0, 0, 0), ex(12'h0, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), ex(B_ST | B_RT | B_SV, 0, 0));
    push(st(0, 0, 0, 0, 0, 1), ex(AL_O | B_CWR, 0, 0));
    push(st(0, 0, 0, 0, 0, 1), ex(AL_O | B_CWR, 1, 0));
    push(st(0, 0, 0, 0, 0, 1), ex(AL_O | B_CWR, 2, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid_pre cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 16'h0) begin
      n_err++;
      $display("FAIL reset_mid_abort got=%h exp=%h", obs, 16'h0);
    end
    drive(st(0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    cyc = 0;
    push(st(1, 0, 0, 0, 0, 0), ex(12'h0, 0, 0));
    push(st(0, 0, 0, 0, 0, 0), ex(B_ST | B_RT | B_SV, 0, 0));
    push(st(0, 0, 0, 0, 0, 1), ex(AL_O | B_CWR, 0, 0));
    push(st(0, 0, 0, 0, 0, 1), ex(AL_O | B_CWR, 1, 0));
    while (stim_q.size() != 0) begin
      drive(stim_q.pop_front());
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid_restart cyc%0d got=%h exp=%h", cyc, obs, e);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_clean_miss();
    test_dirty_store_miss();
    test_no_alloc_store();
    test_flush();
    test_back_to_back();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_fsm_burst.md
Name: cache_ctrl_fsm_burst

Overview:
Parametrised data-cache controller FSM with registered CPU request capture, multi-beat write-back and refill bursts, and a full-cache flush walk. It sits between the load/store unit and the cache arrays/memory interface, and drives the array enables, tag-update controls and the pipeline stall. Write-allocate is selectable, so stores may bypass the array on a miss.

Parameters:
NUM_LINES, 64, cache lines (power of 2, >=2)
BEATS, 4, memory beats per line (power of 2, >=1)
WRITE_ALLOC, 1, 1 = allocate on store miss; 0 = store miss writes memory directly (single beat), no allocate

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cpu_rden  in  1  load request
cpu_wren  in  1  store request
flush_req  in  1  level; start a write-back of all dirty lines
hit  in  1  tag match and valid for current index
dirty  in  1  selected/victim line dirty
mem_ack  in  1  one memory beat accepted (write) or returned (read)
cache_rden  out  1  array read enable
cache_wren  out  1  array write enable
cache_insel  out  1  1 = array data from memory, 0 = from CPU
mem_rden  out  1  memory read burst active
mem_wren  out  1  memory write burst active
set_dirty  out  1  dirty bit value written with the tag
set_valid  out  1  valid bit value written with the tag
replace_tag  out  1  tag/valid/dirty write strobe
tag_sel  out  1  1 = memory address uses stored tag (victim); 0 = CPU tag
beat_idx  out  $clog2(BEATS) (min 1)  current beat within line
flush_idx  out  $clog2(NUM_LINES)  line index during flush
index_sel  out  1  1 = array index from flush_idx
stall  out  1  hold pipeline
flush_done  out  1  one-cycle pulse when flush completes

Behaviour:
- States: IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE, CACHE_ACCESS, MEM_WRITE, FLUSH_CHECK, FLUSH_WB.
- Reset (rst low, async): state IDLE; beat_idx, flush_idx, captured rd/wr flags all 0; all outputs 0.
- cpu_rden/cpu_wren are captured into rd_q/wr_q on every IDLE->COMPARE_TAG entry, and on CACHE_ACCESS/hit-COMPARE_TAG back-to-back entries. Simultaneous rd and wr: wr takes priority.
- IDLE: flush_req takes priority over a CPU request -> FLUSH_CHECK with flush_idx=0. Otherwise, a CPU request -> COMPARE_TAG. stall=0.
- COMPARE_TAG, hit: cache_rden=rd_q, cache_wren=wr_q, replace_tag=wr_q, set_dirty=1, set_valid=1, stall=0. Next state is COMPARE_TAG if a new request is present, else IDLE. Latency: hit data is available 1 cycle after COMPARE_TAG entry.
- COMPARE_TAG, miss, wr_q and WRITE_ALLOC=0 -> MEM_WRITE with stall=1.
- COMPARE_TAG, miss and dirty -> WRITE_BACK with tag_sel=1, stall=1.
- COMPARE_TAG, miss and clean -> ALLOCATE with stall=1. replace_tag=1, set_valid=1, set_dirty=wr_q.
- WRITE_BACK: mem_wren=1, cache_rden=1, tag_sel=1. Each mem_ack increments beat_idx. mem_ack at beat_idx==BEATS-1 wraps beat_idx to 0 and moves to ALLOCATE.
- ALLOCATE: mem_rden=1, cache_insel=1, cache_wren=mem_ack (one array write per beat). Last beat -> CACHE_ACCESS, beat_idx=0, replace_tag pulse with set_valid=1, set_dirty=wr_q.
- CACHE_ACCESS: cache_rden=rd_q, cache_wren=wr_q, cache_insel=0, stall=0. Next state as for a hit.
- MEM_WRITE: mem_wren=1, stall=1 until mem_ack, then IDLE (no tag change).
- FLUSH_CHECK: index_sel=1, stall=1. If dirty -> FLUSH_WB. Else, if flush_idx==NUM_LINES-1 -> IDLE with flush_done pulse; otherwise flush_idx++.
- FLUSH_WB: same beat rules as WRITE_BACK, plus replace_tag=1, set_dirty=0, set_valid=1 on the last beat. Then return to FLUSH_CHECK (last index -> IDLE + flush_done).
- mem_ack outside a burst state is ignored. No beat is lost when mem_ack is held high continuously: one beat per cycle.
- Reset mid-burst aborts immediately; beat_idx=0. There is no memory-side cancel signal; the memory model is reset together with this block.
- default/illegal state -> IDLE, all outputs 0.

Decomposition:
- Package cache_pkg: state enum typedef (explicit 3-bit encoding), BEAT_W/IDX_W localparam functions, output-bundle struct.
- Sub-module cache_beat_cnt: parametrised wrap counter with inc, clear and last outputs, used for beat_idx.
- flush_idx stays as an inline counter.

Test Plan:
- Load hit, BEATS=4: rd at idle, hit=1 -> cache_rden=1 in the cycle after the request, stall never asserted, next state IDLE.
- Clean load miss: hit=0, dirty=0, mem_ack on 4 consecutive cycles -> 4 cache_wren pulses with beat_idx 0,1,2,3. Then replace_tag with set_valid=1, set_dirty=0. stall is high for exactly 5 cycles (COMPARE_TAG plus 4 ALLOCATE beats) and drops in CACHE_ACCESS.
- Dirty store miss, mem_ack every other cycle -> 4 WRITE_BACK beats with tag_sel=1, then 4 ALLOCATE beats, final set_dirty=1. beat_idx returns to 0.
- WRITE_ALLOC=0 store miss -> single MEM_WRITE, mem_wren held until mem_ack, no replace_tag, back to IDLE.
- Flush, NUM_LINES=4, lines 1 and 3 dirty -> flush_idx steps 0..3, two FLUSH_WB bursts, one flush_done pulse. flush_req and cpu_rden applied together -> flush wins.
- rst low at beat 2 of ALLOCATE -> all outputs 0 and beat_idx=0 immediately. Next request starts from beat 0.
